// File: rtl/instr_fetch.sv
// instr_fetch: PC-driven fetch stage issuing reads to a 1-cycle synchronous memory
// and holding each returned word behind a valid/ready handshake to the decoder.
module instr_fetch #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic              flush,
  input  logic [ADDR_W-1:0] pc,
  output logic              pc_incr,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_addr,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [CNT_W-1:0]  fetch_count
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_e;
  state_e              state_q;
  logic [ADDR_W-1:0]   issue_addr_q;
  logic                pc_incr_q;
  logic [DATA_W-1:0]   instr_q;
  logic [ADDR_W-1:0]   instr_addr_q;
  logic                instr_valid_q;
  logic [CNT_W-1:0]    fetch_count_q;
  assign mem_en      = state_q == ISSUE;
  assign mem_addr    = mem_en ? pc : '0;
  assign pc_incr     = pc_incr_q;
  assign instr       = instr_q;
  assign instr_addr  = instr_addr_q;
  assign instr_valid = instr_valid_q;
  assign fetch_count = fetch_count_q;
  // pc_incr defaults low every cycle so it can only pulse on the WAIT->HOLD edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      issue_addr_q  <= '0;
      pc_incr_q     <= 1'b0;
      instr_q       <= '0;
      instr_addr_q  <= '0;
      instr_valid_q <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      pc_incr_q <= 1'b0;
      if (flush) begin
        instr_valid_q <= 1'b0;
        state_q       <= run ? ISSUE : IDLE;
      end else begin
        case (state_q)
          IDLE:  state_q <= run ? ISSUE : IDLE;
          ISSUE: begin
            issue_addr_q <= pc;
            state_q      <= WAIT;
          end
          WAIT: begin
            instr_q       <= mem_rdata;
            instr_addr_q  <= issue_addr_q;
            instr_valid_q <= 1'b1;
            pc_incr_q     <= 1'b1;
            state_q       <= HOLD;
          end
          HOLD: if (instr_ready) begin
            fetch_count_q <= fetch_count_q + 1'b1;
            instr_valid_q <= 1'b0;
            state_q       <= run ? ISSUE : IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: randomized and directed stimulus, with a scoreboard of expected
// fetch addresses derived from a memory model mem[a]={8'hA5,a} and a PC model.
module tb_instr_fetch;
  localparam int AW = 8, DW = 16, CW = 8;
  logic clk = 0, reset = 0, run = 0, flush = 0, instr_ready = 1;
  logic [AW-1:0] pc, pc_base = '0, incr_cnt = '0;
  logic pc_incr, mem_en, instr_valid;
  logic [AW-1:0] mem_addr, instr_addr;
  logic [DW-1:0] mem_rdata = '0, instr;
  logic [CW-1:0] fetch_count;
  int n_chk = 0, n_fail = 0;

  instr_fetch #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .run(run), .flush(flush), .pc(pc),
    .pc_incr(pc_incr), .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .instr(instr), .instr_addr(instr_addr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  // PC advances once per strobe; memory returns a tagged word, garbage when not read
  assign pc = pc_base + incr_cnt;
  always @(posedge clk) begin
    if (pc_incr) incr_cnt <= incr_cnt + 1'b1;
    mem_rdata <= mem_en ? {8'hA5, mem_addr} : DW'($urandom);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s", name);
  endtask

  // scoreboard: expected word addresses in fetch order
  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] a, last_addr = '0, snap_a = '0;
  logic [DW-1:0] snap_i = '0;
  logic [CW-1:0] cnt_exp = '0;
  logic prev_incr = 0, prev_hold = 0;
  int xfers = 0, cyc = 0, last_cyc = 0, last_gap = 0;

  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      check("reset_outputs", 64'({pc_incr, instr_valid, mem_en, instr, instr_addr, mem_addr, fetch_count}), 64'd0);
      exp_q.delete();
      cnt_exp = '0;
      xfers = 0;
      prev_incr = 0;
      prev_hold = 0;
    end else begin
      check("fetch_count", 64'(fetch_count), 64'(cnt_exp));
      if (mem_en) check("issue_addr", 64'(mem_addr), 64'(pc));
      if (prev_hold) check("stall_stable", 64'({instr_valid, pc_incr, mem_en, instr, instr_addr}), 64'({1'b1, 1'b0, 1'b0, snap_i, snap_a}));
      if (pc_incr) begin
        check("incr_pulse", 64'({prev_incr, instr_valid}), 64'(2'b01));
        exp_q.push_back(pc);
      end
      if (instr_valid && flush) begin
        if (exp_q.size() > 0) a = exp_q.pop_front();
      end else if (instr_valid && instr_ready) begin
        if (exp_q.size() == 0) fail_now("xfer_without_fetch");
        else begin
          a = exp_q.pop_front();
          check("instr_addr", 64'(instr_addr), 64'(a));
          check("instr_word", 64'(instr), 64'({8'hA5, a}));
        end
        cnt_exp++;
        xfers++;
        last_gap = cyc - last_cyc;
        last_cyc = cyc;
        last_addr = instr_addr;
      end
      prev_hold = instr_valid && !instr_ready && !flush;
      snap_i = instr;
      snap_a = instr_addr;
      prev_incr = pc_incr;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_xfers(input int n);
    int k = 0;
    while (xfers < n && k < 2000) begin
      tick();
      k++;
    end
    if (xfers < n) fail_now("timeout_xfers");
  endtask

  task automatic wait_sig(input string name, input bit use_mem_en);
    int k = 0;
    while (!(use_mem_en ? mem_en : instr_valid) && k < 50) begin
      tick();
      k++;
    end
    if (!(use_mem_en ? mem_en : instr_valid)) fail_now(name);
  endtask

  task automatic set_pc(input logic [AW-1:0] v);
    pc_base = v - incr_cnt;
  endtask

  initial begin
    logic [AW-1:0] h;
    logic [CW-1:0] c;
    int n;
    repeat (3) tick();
    @(negedge clk);
    #1 reset = 1;
    // back-to-back fetch from pc=0
    tick();
    run = 1;
    wait_xfers(3);
    check("throughput_gap", 64'(last_gap), 64'd3);
    check("count_after_3", 64'(fetch_count), 64'd3);
    // backpressure for 5 cycles
    instr_ready = 0;
    wait_sig("timeout_valid_bp", 0);
    h = instr_addr;
    repeat (5) tick();
    c = fetch_count;
    instr_ready = 1;
    tick();
    check("bp_count", 64'(fetch_count), 64'(c + 1'b1));
    check("bp_valid_drop", 64'(instr_valid), 64'd0);
    check("bp_next_issue", 64'({mem_en, mem_addr}), 64'({1'b1, h + 1'b1}));
    // flush in WAIT at pc=8'h10
    run = 0;
    repeat (6) tick();
    set_pc(8'h10);
    run = 1;
    wait_sig("timeout_issue_flush", 1);
    tick();
    flush = 1;
    tick();
    flush = 0;
    check("flush_wait_reissue", 64'({mem_en, mem_addr}), 64'({1'b1, 8'h10}));
    check("flush_wait_no_capture", 64'({pc_incr, instr_valid}), 64'd0);
    n = xfers + 1;
    wait_xfers(n);
    check("flush_wait_refetch", 64'(last_addr), 64'h10);
    // flush with ready in HOLD
    instr_ready = 0;
    wait_sig("timeout_valid_flush", 0);
    c = fetch_count;
    flush = 1;
    instr_ready = 1;
    tick();
    flush = 0;
    check("flush_hold_count", 64'(fetch_count), 64'(c));
    check("flush_hold_valid", 64'(instr_valid), 64'd0);
    // run dropped during WAIT
    wait_sig("timeout_issue_run", 1);
    tick();
    run = 0;
    n = xfers + 1;
    wait_xfers(n);
    check("run_drop_idle", 64'({mem_en, instr_valid}), 64'd0);
    repeat (3) begin
      tick();
      check("idle_no_issue", 64'(mem_en), 64'd0);
    end
    h = pc;
    run = 1;
    wait_sig("timeout_resume", 1);
    check("resume_addr", 64'(mem_addr), 64'(h));
    // pc wrap
    run = 0;
    repeat (6) tick();
    set_pc(8'hFE);
    run = 1;
    for (int i = 0; i < 3; i++) begin
      h = 8'hFE + AW'(i);
      n = xfers + 1;
      wait_xfers(n);
      check("pc_wrap_addr", 64'(last_addr), 64'(h));
    end
    // fetch_count wrap
    wait_xfers(1 << CW);
    check("count_wrap", 64'(fetch_count), 64'd0);
    // random traffic
    repeat (600) begin
      tick();
      run = $urandom_range(0, 9) != 0;
      instr_ready = $urandom_range(0, 9) < 6;
      flush = $urandom_range(0, 19) == 0;
    end
    // async reset while holding a word
    tick();
    flush = 0;
    run = 1;
    instr_ready = 0;
    wait_sig("timeout_valid_rst", 0);
    @(posedge clk);
    #3 reset = 0;
    #1;
    check("rst_valid", 64'(instr_valid), 64'd0);
    check("rst_incr", 64'(pc_incr), 64'd0);
    check("rst_count", 64'(fetch_count), 64'd0);
    check("rst_instr", 64'(instr), 64'd0);
    @(negedge clk);
    #1 reset = 1;
    instr_ready = 1;
    wait_xfers(2);
    check("restart_count", 64'(fetch_count), 64'd2);
    run = 0;
    repeat (8) tick();
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Fetch stage directly downstream of the program counter.
- Reads the current PC value and issues a read to a synchronous instruction memory with 1-cycle read latency.
- Holds the returned word in a one-entry output register behind a valid/ready handshake to the decoder.
- Drives the PC increment strobe once per fetched word.

Parameters:
ADDR_W, 8, width of PC value and memory address
DATA_W, 16, instruction word width
CNT_W, 16, width of fetched-instruction counter

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous, active-low reset (asserted at 0)
run  in  1  fetch enable; level-sensitive
flush  in  1  discard held/in-flight instruction, return to idle/issue
pc  in  ADDR_W  current PC value from the program counter
pc_incr  out  1  increment strobe to the PC; registered, one-cycle pulse
mem_en  out  1  memory read enable
mem_addr  out  ADDR_W  memory read address
mem_rdata  in  DATA_W  memory read data, valid the cycle after mem_en
instr  out  DATA_W  fetched instruction word (registered)
instr_addr  out  ADDR_W  address the held word was fetched from (registered)
instr_valid  out  1  instr/instr_addr hold a word not yet accepted
instr_ready  in  1  decoder accepts word when instr_valid && instr_ready
fetch_count  out  CNT_W  number of accepted transfers, wraps modulo 2^CNT_W

Behaviour:
- Reset (reset=0, async): state IDLE; pc_incr=0, instr=0, instr_addr=0, instr_valid=0, fetch_count=0. mem_en=0 and mem_addr=0, combinationally from IDLE. Reset mid-fetch abandons all work with no pc_incr.
- States: IDLE, ISSUE, WAIT, HOLD.
- IDLE: mem_en=0. run=1 -> ISSUE, else stay.
- ISSUE: mem_en=1, mem_addr=pc (combinational); latch pc into an internal issue-address register. Next state is WAIT unconditionally.
- WAIT: mem_en=0; mem_rdata is valid this cycle. At the clock edge: instr<=mem_rdata, instr_addr<=issue address, instr_valid<=1, pc_incr<=1. Next state is HOLD.
- HOLD: instr_valid=1. pc_incr is high only in the first HOLD cycle, then 0; it is never high two consecutive cycles, which guarantees PC edge detection.
  - instr_ready=1: transfer; fetch_count+1; instr_valid<=0; next state ISSUE if run=1, else IDLE.
  - instr_ready=0: stay; instr/instr_addr stable.
- PC timing: PC updates at the edge ending the first HOLD cycle. The next ISSUE therefore always sees the incremented pc.
- Throughput: 3 cycles per instruction with instr_ready held 1. Each backpressure cycle adds one cycle.
- run deassert: an in-progress fetch (ISSUE/WAIT/HOLD) completes through its handshake, then goes to IDLE. run has no effect until the current word is transferred.
- flush (highest priority after reset), any state:
  - instr_valid<=0 and pc_incr<=0; in WAIT, mem_rdata is discarded, no capture, no pc_incr.
  - Next state ISSUE if run=1, else IDLE.
  - flush with instr_ready in HOLD: no transfer, fetch_count unchanged.
  - A flush in HOLD does not undo the PC increment already issued.
- pc wrap: mem_addr follows pc unchanged; e.g. 8'hFF fetched, then PC's wrap to 8'h00 is fetched normally.
- fetch_count wraps from 2^CNT_W-1 to 0 without flag.
- No combinational path from instr_ready to instr_valid; mem_en/mem_addr depend only on state and pc.

Test Plan:
- Memory model mem[a]={8'hA5,a}, PC model from pc_incr. Release reset, run=1, instr_ready=1, pc=0 -> instr 16'hA500,16'hA501,16'hA502 at addr 0,1,2; instr_valid one cycle in every 3; fetch_count=3; pc_incr exactly one pulse per word.
- Hold instr_ready=0 for 5 cycles while instr_valid -> instr/instr_addr stable, pc_incr single pulse, no new mem_en. Release -> one transfer, fetch_count+1, next ISSUE uses pc+1.
- flush asserted in WAIT at pc=8'h10 -> no capture, no pc_incr, re-ISSUE reads address 8'h10 again. Flush with instr_ready=1 in HOLD -> fetch_count unchanged.
- run dropped during WAIT -> word captured, transfers on ready, then IDLE with mem_en=0. run re-raised -> fetch resumes at next pc.
- Start pc=8'hFE, 3 fetches -> addresses 8'hFE,8'hFF,8'h00. Preset fetch_count near 16'hFFFF via 65535 transfers (or forced) -> wraps to 0.
- Assert reset=0 in HOLD with instr_valid=1 -> instr_valid, pc_incr, fetch_count, instr drop to 0 immediately (async). After release, run=1 -> fetch restarts from IDLE.
